ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_key_decoder_if.sv | 32 +++
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 rtl/ps2_key_decoder.sv | 120 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  // Scan-code prefix bytes.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Frame receiver states: start bit, 8 data bits, parity bit, stop bit.
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bus between the keyboard front end and its consumer: raw PS/2 lines in,
// decoded scan-code events and watched-key state out.
interface ps2_key_decoder_if #(
  parameter int unsigned NUM_KEYS = 4
) ();

  logic                ps2c;
  logic                ps2d;
  logic [7:0]          code;
  logic                code_valid;
  logic                code_ext;
  logic                code_break;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                frame_err;

  // Decoder side.
  modport master (
    input  ps2c, ps2d,
    output code, code_valid, code_ext, code_break,
    output key_down, key_press, key_release, frame_err
  );

  // Keyboard / game-logic side.
  modport slave (
    output ps2c, ps2d,
    input  code, code_valid, code_ext, code_break,
    input  key_down, key_press, key_release, frame_err
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: ps2c glitch filter, ps2d synchroniser, 11-bit frame
// FSM with parity/stop checking and an inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,       // must be >= 2
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned   TmoW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  lvl_q, lvl_d;
  logic                  fall_q, fall_d;
  logic                  d_meta_q, d_sync_q;
  rx_state_e             state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_q, par_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;

  // Filter: level only moves once the whole window agrees; fall is the 1->0 of that level.
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], ps2c_i};
    lvl_d  = lvl_q;
    if (&filt_q) begin
      lvl_d = 1'b1;
    end else if (~|filt_q) begin
      lvl_d = 1'b0;
    end
    fall_d = lvl_q & ~lvl_d;
  end

  // Frame FSM and timeout; ps2d is sampled on each registered fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == StIdle || fall_q) ? '0 : tmo_q + 1'b1;

    // A stalled keyboard mid-frame drops the partial byte.
    if (state_q != StIdle && !fall_q && tmo_q == TmoLast) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
      tmo_d       = '0;
    end else if (fall_q) begin
      unique case (state_q)
        StIdle: begin
          if (d_sync_q) begin
            frame_err_d = 1'b1;
          end else begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {d_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = d_sync_q;
          state_d = StStop;
        end
        StStop: begin
          if (d_sync_q && (^{shift_q, par_q})) begin
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q      <= '1;
      lvl_q       <= 1'b1;
      fall_q      <= 1'b0;
      d_meta_q    <= 1'b1;
      d_sync_q    <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      lvl_q       <= lvl_d;
      fall_q      <= fall_d;
      d_meta_q    <= ps2d_i;
      d_sync_q    <= d_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // shift_q is untouched in idle, so it still holds the byte during the rx_valid cycle.
  assign rx_byte_o   = shift_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame receiver plus E0/F0 prefix decoding and
// held-state tracking of a small set of watched keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned                FILTER_LEN  = 8,
  parameter int unsigned                TIMEOUT_CYC = 100000,
  parameter int unsigned                NUM_KEYS    = 4,
  parameter logic [8*NUM_KEYS-1:0]      KEY_CODES   = {8'h72, 8'h75, 8'h5A, 8'h29},
  parameter logic [NUM_KEYS-1:0]        KEY_EXT     = 4'b1100
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_key_decoder_if.master    bus
);

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                frame_err;

  logic [7:0]          code_q, code_d;
  logic                code_valid_q, code_valid_d;
  logic                code_ext_q, code_ext_d;
  logic                code_break_q, code_break_d;
  logic                ext_pend_q, ext_pend_d;
  logic                brk_pend_q, brk_pend_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2c_i      (bus.ps2c),
    .ps2d_i      (bus.ps2d),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err)
  );

  // Prefix decoding and key tracking; every watched key matching the code is updated.
  always_comb begin
    code_d        = code_q;
    code_valid_d  = 1'b0;
    code_ext_d    = code_ext_q;
    code_break_d  = code_break_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    key_down_d    = key_down_q;
    key_press_d   = '0;
    key_release_d = '0;

    if (frame_err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        code_d       = rx_byte;
        code_valid_d = 1'b1;
        code_ext_d   = ext_pend_q;
        code_break_d = brk_pend_q;
        ext_pend_d   = 1'b0;
        brk_pend_d   = 1'b0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
          if (rx_byte == KEY_CODES[8*i +: 8] && ext_pend_q == KEY_EXT[i]) begin
            if (brk_pend_q) begin
              key_down_d[i]    = 1'b0;
              key_release_d[i] = key_down_q[i];
            end else begin
              key_down_d[i]  = 1'b1;
              key_press_d[i] = ~key_down_q[i];
            end
          end
        end
      end
    end
  end

  // Decoder registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q        <= 8'h00;
      code_valid_q  <= 1'b0;
      code_ext_q    <= 1'b0;
      code_break_q  <= 1'b0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      key_down_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      code_q        <= code_d;
      code_valid_q  <= code_valid_d;
      code_ext_q    <= code_ext_d;
      code_break_q  <= code_break_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign bus.code        = code_q;
  assign bus.code_valid  = code_valid_q;
  assign bus.code_ext    = code_ext_q;
  assign bus.code_break  = code_break_q;
  assign bus.key_down    = key_down_q;
  assign bus.key_press   = key_press_q;
  assign bus.key_release = key_release_q;
  assign bus.frame_err   = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frames followed by random frame
// traffic, checked against a scan-code / key-state reference model.
module tb_ps2_key_decoder;

  localparam int unsigned FiltLen = 4;
  localparam int unsigned TmoCyc  = 200;
  localparam int unsigned NKeys   = 4;
  localparam int unsigned Half    = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_key_decoder_if #(.NUM_KEYS(NKeys)) bus ();

  ps2_key_decoder #(
    .FILTER_LEN  (FiltLen),
    .TIMEOUT_CYC (TmoCyc),
    .NUM_KEYS    (NKeys),
    .KEY_CODES   ({8'h72, 8'h75, 8'h5A, 8'h29}),
    .KEY_EXT     (4'b1100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: running totals only, the stimulus side takes snapshots.
  int         cv_tot = 0, err_tot = 0, stray_tot = 0, cv_cyc = 0;
  logic [7:0] last_code;
  logic       last_ext, last_brk;
  int         press_tot [NKeys] = '{default: 0};
  int         rel_tot   [NKeys] = '{default: 0};

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.code_valid) begin
        cv_tot++;
        cv_cyc    = cyc;
        last_code = bus.code;
        last_ext  = bus.code_ext;
        last_brk  = bus.code_break;
      end
      if (bus.frame_err) err_tot++;
      if ((bus.key_press != '0 || bus.key_release != '0) && !bus.code_valid) stray_tot++;
      for (int i = 0; i < int'(NKeys); i++) begin
        if (bus.key_press[i]) press_tot[i]++;
        if (bus.key_release[i]) rel_tot[i]++;
      end
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: pending prefixes and held keys.
  logic [7:0]       key_tab [NKeys] = '{8'h29, 8'h5A, 8'h75, 8'h72};
  logic             ext_tab [NKeys] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit               m_ext, m_brk;
  logic [NKeys-1:0] m_down;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_down = '0;
  endtask

  task automatic model_err();
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ev, output logic [7:0] e_code,
                            output bit e_ext, output bit e_brk,
                            output logic [NKeys-1:0] pr, output logic [NKeys-1:0] rl);
    ev = 0; e_code = 8'h00; e_ext = 0; e_brk = 0; pr = '0; rl = '0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      ev = 1; e_code = b; e_ext = m_ext; e_brk = m_brk;
      for (int i = 0; i < int'(NKeys); i++) begin
        if (key_tab[i] == b && ext_tab[i] == m_ext) begin
          if (m_brk) begin
            rl[i] = m_down[i];
            m_down[i] = 1'b0;
          end else begin
            pr[i] = ~m_down[i];
            m_down[i] = 1'b1;
          end
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Snapshots of the monitor totals.
  int s_cv, s_err, s_stray;
  int s_press [NKeys];
  int s_rel   [NKeys];
  int stop_fall_cyc;

  task automatic snap();
    s_cv = cv_tot; s_err = err_tot; s_stray = stray_tot;
    for (int i = 0; i < int'(NKeys); i++) begin
      s_press[i] = press_tot[i];
      s_rel[i]   = rel_tot[i];
    end
  endtask

  // Send bits[0..n-1]; data is set mid-high, ps2c falls Half cycles later.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk) bus.ps2d = bits[j];
      repeat (Half) @(negedge clk);
      bus.ps2c = 1'b0;
      stop_fall_cyc = cyc;
      repeat (Half) @(negedge clk);
      bus.ps2c = 1'b1;
    end
    @(negedge clk) bus.ps2d = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  function automatic logic [31:0] all_outs();
    return {8'h00, bus.code, bus.code_valid, bus.code_ext, bus.code_break, bus.key_down,
            bus.key_press, bus.key_release, bus.frame_err};
  endfunction

  // kind: 0 good, 1 bad parity, 2 bad stop.
  task automatic check_frame(input string tag, input logic [7:0] b, input int kind);
    bit               ev, e_ext, e_brk;
    logic [7:0]       e_code;
    logic [NKeys-1:0] pr, rl;
    int               lat;
    snap();
    send_bits(mk_frame(b, kind == 1, kind == 2), 11);
    repeat (8) @(negedge clk);
    if (kind == 0) model_byte(b, ev, e_code, e_ext, e_brk, pr, rl);
    else begin
      model_err();
      ev = 0; pr = '0; rl = '0;
    end
    check_eq($sformatf("%s.cv", tag), cv_tot - s_cv, ev);
    if (ev) begin
      lat = cv_cyc - stop_fall_cyc;
      check_eq($sformatf("%s.code", tag), last_code, e_code);
      check_eq($sformatf("%s.ext", tag), last_ext, e_ext);
      check_eq($sformatf("%s.brk", tag), last_brk, e_brk);
      check_eq($sformatf("%s.lat%0d", tag, lat),
               (lat >= int'(FiltLen) + 2 && lat <= int'(FiltLen) + 5), 1);
    end
    check_eq($sformatf("%s.err", tag), err_tot - s_err, (kind != 0));
    check_eq($sformatf("%s.down", tag), bus.key_down, m_down);
    for (int i = 0; i < int'(NKeys); i++) begin
      check_eq($sformatf("%s.press%0d", tag, i), press_tot[i] - s_press[i], pr[i]);
      check_eq($sformatf("%s.rel%0d", tag, i), rel_tot[i] - s_rel[i], rl[i]);
    end
    check_eq($sformatf("%s.stray", tag), stray_tot - s_stray, 0);
  endtask

  // Start bit plus k data bits, then ps2c stalls past the timeout.
  task automatic check_timeout(input string tag, input logic [7:0] b, input int k);
    snap();
    send_bits(mk_frame(b, 0, 0), k + 1);
    repeat (TmoCyc + 40) @(negedge clk);
    model_err();
    check_eq($sformatf("%s.err", tag), err_tot - s_err, 1);
    check_eq($sformatf("%s.cv", tag), cv_tot - s_cv, 0);
    check_eq($sformatf("%s.down", tag), bus.key_down, m_down);
  endtask

  task automatic check_bad_start(input string tag);
    snap();
    send_bits(11'h7FF, 1);
    repeat (8) @(negedge clk);
    model_err();
    check_eq($sformatf("%s.err", tag), err_tot - s_err, 1);
    check_eq($sformatf("%s.cv", tag), cv_tot - s_cv, 0);
  endtask

  // ps2c low pulse shorter than the filter window.
  task automatic glitch();
    bus.ps2c = 1'b0;
    repeat (FiltLen - 2) @(negedge clk);
    bus.ps2c = 1'b1;
    repeat (FiltLen + 1) @(negedge clk);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         r;
    reset = 1'b1;
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset.outs", all_outs(), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check_frame("k29", 8'h29, 0);
    check_frame("k29rep", 8'h29, 0);
    check_frame("f0", 8'hF0, 0);
    check_frame("k29brk", 8'h29, 0);
    check_frame("e0", 8'hE0, 0);
    check_frame("e75", 8'h75, 0);
    check_frame("n75", 8'h75, 0);
    check_frame("5a_badpar", 8'h5A, 1);
    check_frame("5a", 8'h5A, 0);
    check_frame("f0a", 8'hF0, 0);
    check_frame("f0b", 8'hF0, 0);
    check_frame("5abrk", 8'h5A, 0);
    check_timeout("tmo4", 8'h29, 4);
    check_frame("k29tmo", 8'h29, 0);
    check_frame("e0err", 8'hE0, 0);
    check_frame("badstop", 8'h72, 2);
    check_frame("72plain", 8'h72, 0);
    check_bad_start("badstart");

    // Reset in the middle of a frame while key 0 is held.
    send_bits(mk_frame(8'h5A, 0, 0), 4);
    snap();
    @(negedge clk) reset = 1'b1;
    repeat (3) glitch();
    check_eq("rst.outs", all_outs(), 0);
    reset = 1'b0;
    model_reset();
    repeat (3) glitch();
    repeat (10) @(negedge clk);
    check_eq("rst.post_outs", all_outs(), 0);
    check_eq("rst.err", err_tot - s_err, 0);
    check_eq("rst.cv", cv_tot - s_cv, 0);
    check_frame("rst.k29", 8'h29, 0);

    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: b = 8'h29;
        1: b = 8'h5A;
        2: b = 8'h75;
        3: b = 8'h72;
        4: b = 8'hE0;
        5: b = 8'hF0;
        6: b = 8'hAA;
        default: b = 8'($urandom);
      endcase
      r = $urandom_range(0, 12);
      if (r < 9) check_frame($sformatf("rnd%0d", n), b, 0);
      else if (r == 9) check_frame($sformatf("rnd%0d_par", n), b, 1);
      else if (r == 10) check_frame($sformatf("rnd%0d_stop", n), b, 2);
      else if (r == 11) check_timeout($sformatf("rnd%0d_tmo", n), b, $urandom_range(0, 7));
      else check_bad_start($sformatf("rnd%0d_start", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
